// File: rtl/decoder_seq_n.sv
// -----------------------------------------------------------------------------
// decoder_seq_n
//   Registered SEL_W-to-2^SEL_W one-hot decoder driven by a small command
//   interface. A command selects one of four modes:
//     STATIC - hold one line high until the next command
//     PULSE  - drive one line high for len_eff enabled cycles, then flag done
//     SCAN   - rotate a single high line, dwelling len_eff cycles per index
//     CLEAR  - drop all lines and return to idle
//
// Ports
//   clk        rising-edge clock for all state
//   rst_n      asynchronous active-low reset
//   enable     global enable; when low, out is forced to 0 and state freezes
//   cmd_valid  command present
//   cmd_ready  command can be accepted this cycle (combinational)
//   cmd_mode   00 STATIC, 01 PULSE, 10 SCAN, 11 CLEAR
//   cmd_sel    start / target index
//   cmd_len    dwell (SCAN) or pulse length (PULSE); 0 behaves as 1
//   out        one-hot (or all-zero) decoded output
//   cur_sel    index currently driven (registered)
//   busy       high whenever the sequencer is not idle
//   done       one-cycle pulse after the last cycle of a PULSE
// -----------------------------------------------------------------------------
module decoder_seq_n #(
  parameter int SEL_W = 3,
  parameter int LEN_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_mode,
  input  logic [SEL_W-1:0]        cmd_sel,
  input  logic [LEN_W-1:0]        cmd_len,
  output logic [(2**SEL_W)-1:0]   out,
  output logic [SEL_W-1:0]        cur_sel,
  output logic                    busy,
  output logic                    done
);

  localparam int OUT_W = 2**SEL_W;

  localparam logic [1:0] MODE_STATIC = 2'b00;
  localparam logic [1:0] MODE_PULSE  = 2'b01;
  localparam logic [1:0] MODE_SCAN   = 2'b10;
  localparam logic [1:0] MODE_CLEAR  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_HOLD  = 2'b01,
    ST_PULSE = 2'b10,
    ST_SCAN  = 2'b11
  } state_e;

  state_e             state_q,   state_d;
  logic [OUT_W-1:0]   out_q,     out_d;
  logic [SEL_W-1:0]   cur_sel_q, cur_sel_d;
  logic [LEN_W-1:0]   cnt_q,     cnt_d;
  // Latched len_eff-1 so later cmd_len changes cannot disturb a running scan.
  logic [LEN_W-1:0]   reload_q,  reload_d;
  logic               done_q,    done_d;

  logic               cmd_ready_s;
  logic               accept_s;
  logic [LEN_W-1:0]   len_m1_s;
  logic [OUT_W-1:0]   sel_onehot_s;

  // Command handshake and decoded command fields.
  always_comb begin
    cmd_ready_s  = enable & (state_q != ST_PULSE);
    accept_s     = cmd_valid & cmd_ready_s;
    // A zero length behaves as one cycle, so the counter preload is len-1 or 0.
    if (cmd_len == {LEN_W{1'b0}}) begin
      len_m1_s = {LEN_W{1'b0}};
    end else begin
      len_m1_s = cmd_len - LEN_W'(1);
    end
    sel_onehot_s = {{(OUT_W-1){1'b0}}, 1'b1} << cmd_sel;
  end

  // Sequencer next-state: command load, pulse countdown and scan rotation.
  always_comb begin
    state_d   = state_q;
    out_d     = out_q;
    cur_sel_d = cur_sel_q;
    cnt_d     = cnt_q;
    reload_d  = reload_q;
    done_d    = done_q;
    if (!enable) begin
      // Frozen: all state, including a pending done, holds until re-enable.
      state_d = state_q;
    end else if (accept_s) begin
      // A new command replaces whatever HOLD/SCAN was doing.
      cur_sel_d = cmd_sel;
      out_d     = sel_onehot_s;
      cnt_d     = len_m1_s;
      reload_d  = len_m1_s;
      done_d    = 1'b0;
      case (cmd_mode)
        MODE_STATIC: state_d = ST_HOLD;
        MODE_PULSE:  state_d = ST_PULSE;
        MODE_SCAN:   state_d = ST_SCAN;
        MODE_CLEAR: begin
          state_d   = ST_IDLE;
          out_d     = {OUT_W{1'b0}};
          cur_sel_d = {SEL_W{1'b0}};
        end
        default:     state_d = ST_IDLE;
      endcase
    end else begin
      done_d = 1'b0;
      case (state_q)
        ST_PULSE: begin
          if (cnt_q == {LEN_W{1'b0}}) begin
            out_d   = {OUT_W{1'b0}};
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - LEN_W'(1);
          end
        end
        ST_SCAN: begin
          if (cnt_q == {LEN_W{1'b0}}) begin
            // Index wraps naturally at OUT_W because cur_sel is SEL_W bits.
            cur_sel_d = cur_sel_q + SEL_W'(1);
            out_d     = {out_q[OUT_W-2:0], out_q[OUT_W-1]};
            cnt_d     = reload_q;
          end else begin
            cnt_d = cnt_q - LEN_W'(1);
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      out_q     <= {OUT_W{1'b0}};
      cur_sel_q <= {SEL_W{1'b0}};
      cnt_q     <= {LEN_W{1'b0}};
      reload_q  <= {LEN_W{1'b0}};
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_q     <= out_d;
      cur_sel_q <= cur_sel_d;
      cnt_q     <= cnt_d;
      reload_q  <= reload_d;
      done_q    <= done_d;
    end
  end

  // Output drive: enable masks out and done immediately, without a cycle of lag.
  always_comb begin
    cmd_ready = cmd_ready_s;
    out       = enable ? out_q : {OUT_W{1'b0}};
    cur_sel   = cur_sel_q;
    busy      = (state_q != ST_IDLE);
    done      = done_q & enable;
  end

endmodule

// File: doc/decoder_seq_n.md
Name: decoder_seq_n

Overview:
Parametrised, registered SEL_W-to-2^SEL_W one-hot decoder with a command interface and a sequencer.
Supports four modes:
- static decode
- timed single pulse
- auto-scan (rotating one-hot, e.g. row/digit strobing)
- clear

Sits between control logic and one-hot select/strobe lines. Replaces purely combinational decoders where outputs must be timed or scanned.

Parameters:
SEL_W, 3, select width; output width OUT_W = 2**SEL_W (localparam, not overridable)
LEN_W, 8, width of dwell/pulse length field and internal dwell counter

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
enable  input  1  global enable, active high
cmd_valid  input  1  command present
cmd_ready  output  1  command can be accepted this cycle
cmd_mode  input  2  00 STATIC, 01 PULSE, 10 SCAN, 11 CLEAR
cmd_sel  input  SEL_W  start/target index
cmd_len  input  LEN_W  dwell (SCAN) or pulse length (PULSE) in cycles; 0 treated as 1
out  output  OUT_W  one-hot decoded output
cur_sel  output  SEL_W  index currently driven (registered)
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse at end of PULSE

Behaviour:
- Reset (async, rst_n=0): state IDLE, out register 0, cur_sel 0, dwell counter 0, done 0, busy 0. Takes effect immediately, including mid-PULSE or mid-SCAN.
- States: IDLE, HOLD, PULSE, SCAN.
- Accept condition: cmd_valid & cmd_ready on a rising edge. The new out/cur_sel values are visible the cycle after accept (1-cycle latency).
- cmd_ready = enable & (state != PULSE), combinational. HOLD and SCAN are pre-emptible by a new command; PULSE is not.
- len_eff = (cmd_len == 0) ? 1 : cmd_len. On accept, the dwell counter loads len_eff-1.
- STATIC: cur_sel<=cmd_sel, out reg<=1<<cmd_sel, state HOLD. Held indefinitely until the next command.
- PULSE:
  - cur_sel<=cmd_sel, out reg<=1<<cmd_sel, state PULSE.
  - out is high for exactly len_eff cycles.
  - When the counter is 0 in PULSE: out reg<=0, state IDLE, and done=1 for that one following cycle (same cycle out returns to 0).
- SCAN:
  - cur_sel<=cmd_sel, out reg<=1<<cmd_sel, state SCAN.
  - When the counter is 0: cur_sel<=cur_sel+1 (modulo OUT_W; wraps OUT_W-1 -> 0), out reg rotates left by 1, counter reloads len_eff-1. Otherwise the counter decrements.
  - len_eff is latched at accept; cmd_len changes afterwards are ignored.
  - Runs until a new command is accepted or reset.
- CLEAR: out reg<=0, cur_sel<=0, state IDLE. CLEAR accepted in IDLE is harmless.
- Command accepted in HOLD/SCAN: new command wins outright. No residual output from the old mode on the next cycle.
- enable=0:
  - out driven 0 combinationally in the same cycle.
  - State, dwell counter and cur_sel frozen.
  - cmd_ready=0; done is not asserted while frozen.
  - On re-enable, the sequence resumes at the same position with the same remaining dwell.
  - A PULSE whose counter is frozen extends its wall-clock length but not its count of enabled cycles.
- Output is always one-hot or all-zero, never multi-hot. The verifier checks $onehot0(out) every cycle.
- busy=0 only in IDLE. done never coincides with cmd_ready=0 caused by PULSE.

Test Plan:
1. Assert rst_n=0 mid-SCAN (async, between edges) -> out=0x00, busy=0, cur_sel=0 immediately. After release, cmd_ready=1 with enable=1.
2. STATIC sel=5 -> out=0x20 from the cycle after accept, held 20 cycles. Then STATIC sel=0 -> out=0x01 next cycle.
3. PULSE sel=2 len=3 -> out=0x04 for exactly 3 cycles, then out=0x00 with done=1 for 1 cycle. cmd_ready=0 during the pulse; a STATIC held on cmd_valid is accepted the cycle done is high.
4. SCAN sel=6 len=2 -> out 0x40,0x40,0x80,0x80,0x01,0x01,0x02; cur_sel 6,6,7,7,0,0,1. Then CLEAR -> out=0x00, busy=0 next cycle.
5. SCAN sel=0 len=4; drop enable for 3 cycles after 2 cycles at 0x01 -> out=0x00 during the gap. Then 2 more cycles of 0x01, then 0x02.
6. PULSE sel=7 len=0 -> out=0x80 for exactly 1 cycle, done next cycle. Also run SCAN len=0 -> index advances every cycle.
